// File: rtl/tdm_demux_1to4_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 1-to-4 TDM demultiplexer.
//   tdm_state_t     : framing FSM states (HUNT / RECEIVE)
//   NUM_SLOTS       : slots per TDM frame
//   SLOT_A..SLOT_D  : slot indices; identical to the 4-to-1 mux select
//                     encoding so slot n lands on the same output letter
//                     the mux would pick with sel == n.
// ---------------------------------------------------------------------------
package tdm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } tdm_state_t;

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] SLOT_A = 2'b00;
  localparam logic [1:0] SLOT_B = 2'b01;
  localparam logic [1:0] SLOT_C = 2'b10;
  localparam logic [1:0] SLOT_D = 2'b11;

endpackage : tdm_pkg

// File: rtl/tdm_demux_1to4.sv
// ---------------------------------------------------------------------------
// tdm_demux_1to4
// Receives a serialized stream of 4-slot frames and presents each complete
// frame on four parallel outputs. frame_sync (qualified by din_valid) marks
// slot 0. Slots 0..2 are held in shadow registers; when slot 3 arrives the
// whole frame is copied to a..d in one edge, so partial frames are never
// visible.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   din          in   [WIDTH-1:0] serialized sample
//   din_valid    in   din carries a sample this cycle
//   frame_sync   in   sample is slot 0 (only meaningful with din_valid)
//   a, b, c, d   out  [WIDTH-1:0] slots 0..3 of the last complete frame
//   slot         out  [1:0] slot index of the next accepted sample
//   locked       out  high while in RECEIVE
//   frame_valid  out  one-cycle pulse, a..d were just updated
//   sync_err     out  one-cycle pulse, framing violation detected
// ---------------------------------------------------------------------------
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  tdm_state_t       state_r, state_s;
  logic [1:0]       slot_r, slot_s;
  logic [WIDTH-1:0] sh0_r, sh0_s;
  logic [WIDTH-1:0] sh1_r, sh1_s;
  logic [WIDTH-1:0] sh2_r, sh2_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] c_r, c_s;
  logic [WIDTH-1:0] d_r, d_s;
  logic             frame_valid_r, frame_valid_s;
  logic             sync_err_r, sync_err_s;

  // Next-state logic for the framing FSM, slot counter, shadow bank and outputs.
  always_comb begin
    state_s       = state_r;
    slot_s        = slot_r;
    sh0_s         = sh0_r;
    sh1_s         = sh1_r;
    sh2_s         = sh2_r;
    a_s           = a_r;
    b_s           = b_r;
    c_s           = c_r;
    d_s           = d_r;
    frame_valid_s = 1'b0;
    sync_err_s    = 1'b0;

    if (din_valid) begin
      case (state_r)
        HUNT: begin
          if (frame_sync) begin
            sh0_s   = din;
            slot_s  = SLOT_B;
            state_s = RECEIVE;
          end else begin
            // Unaligned sample while hunting: discard.
            slot_s  = SLOT_A;
            state_s = HUNT;
          end
        end

        RECEIVE: begin
          if (frame_sync) begin
            // A marker always restarts the frame at slot 0. It is only an
            // error when it cuts a partial frame short; at a frame boundary
            // it is the expected marker. A marker on slot 3 therefore
            // discards the frame instead of completing it.
            sh0_s      = din;
            slot_s     = SLOT_B;
            sync_err_s = (slot_r != SLOT_A);
          end else begin
            case (slot_r)
              SLOT_A: begin
                // Expected a marker but none came: alignment lost.
                sync_err_s = 1'b1;
                slot_s     = SLOT_A;
                state_s    = HUNT;
              end
              SLOT_B: begin
                sh1_s  = din;
                slot_s = SLOT_C;
              end
              SLOT_C: begin
                sh2_s  = din;
                slot_s = SLOT_D;
              end
              SLOT_D: begin
                // Last slot goes straight to d; the rest come from shadows.
                a_s           = sh0_r;
                b_s           = sh1_r;
                c_s           = sh2_r;
                d_s           = din;
                frame_valid_s = 1'b1;
                slot_s        = SLOT_A;
              end
              default: begin
                slot_s  = SLOT_A;
                state_s = HUNT;
              end
            endcase
          end
        end

        default: begin
          slot_s  = SLOT_A;
          state_s = HUNT;
        end
      endcase
    end else begin
      // No sample: hold everything, pulses stay low.
      frame_valid_s = 1'b0;
      sync_err_s    = 1'b0;
    end
  end

  // State, shadow and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= HUNT;
      slot_r        <= SLOT_A;
      sh0_r         <= {WIDTH{1'b0}};
      sh1_r         <= {WIDTH{1'b0}};
      sh2_r         <= {WIDTH{1'b0}};
      a_r           <= {WIDTH{1'b0}};
      b_r           <= {WIDTH{1'b0}};
      c_r           <= {WIDTH{1'b0}};
      d_r           <= {WIDTH{1'b0}};
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      slot_r        <= slot_s;
      sh0_r         <= sh0_s;
      sh1_r         <= sh1_s;
      sh2_r         <= sh2_s;
      a_r           <= a_s;
      b_r           <= b_s;
      c_r           <= c_s;
      d_r           <= d_s;
      frame_valid_r <= frame_valid_s;
      sync_err_r    <= sync_err_s;
    end
  end

  assign a           = a_r;
  assign b           = b_r;
  assign c           = c_r;
  assign d           = d_r;
  assign slot        = slot_r;
  assign locked      = (state_r == RECEIVE);
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;

endmodule : tdm_demux_1to4
